// File: rtl/seg_pkg.sv
// Shared types and constants for the 8-digit seven-segment scan controller.
// The BLANK state exists only when SCAN_GHOST_BLANK_EN is defined.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1
`ifdef SCAN_GHOST_BLANK_EN
    ,
    BLANK = 2'd2
`endif
  } scan_state_t;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}, indexed by hex value
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational hex-to-seven-segment decoder, active-low outputs.
module hex7seg_dec
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 8-digit seven-segment scan controller with registered sel/an_n.
// Optional inter-slot anti-ghosting blank enabled by macro SCAN_GHOST_BLANK_EN.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] digit_mask,
  input  logic [3:0] digit_nibble,
  output logic [2:0] sel,
  output logic [7:0] an_n,
  output logic [6:0] seg_n,
  output logic       frame_done
);

  localparam int unsigned CNT_MAX   = (BLANK_CYCLES > TICK_DIV) ? BLANK_CYCLES : TICK_DIV;
  localparam int unsigned CW        = $clog2(CNT_MAX);
  localparam logic [CW-1:0] SHOW_LAST = CW'(TICK_DIV - 1);
`ifdef SCAN_GHOST_BLANK_EN
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
`endif
  localparam logic [2:0] LAST_DIG = 3'(NUM_DIGITS - 1);

  scan_state_t   state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    sel_nx;
  logic [7:0]    an_nx;
  logic          fd_nx;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sel_nx   = sel;
    fd_nx    = 1'b0;
    if (!en) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      sel_nx   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_nx = SHOW;
          cnt_nx   = '0;
          sel_nx   = '0;
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            cnt_nx = '0;
`ifdef SCAN_GHOST_BLANK_EN
            state_nx = BLANK;
`else
            sel_nx = (sel == LAST_DIG) ? '0 : sel + 3'd1;
            fd_nx  = (sel == LAST_DIG);
`endif
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
`ifdef SCAN_GHOST_BLANK_EN
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_nx = SHOW;
            cnt_nx   = '0;
            sel_nx   = (sel == LAST_DIG) ? '0 : sel + 3'd1;
            fd_nx    = (sel == LAST_DIG);
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
`endif
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
          sel_nx   = '0;
        end
      endcase
    end
    // Anodes are decoded from the next state so the register lines up with sel
    an_nx = '1;
    if (state_nx == SHOW && digit_mask[sel_nx])
      an_nx[sel_nx] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sel        <= '0;
      an_n       <= '1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      sel        <= sel_nx;
      an_n       <= an_nx;
      frame_done <= fd_nx;
    end
  end

  hex7seg_dec u_dec (
    .nibble (digit_nibble),
    .seg_n  (seg_n)
  );

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (TICK_DIV=4, BLANK_CYCLES=2).
// Honours SCAN_GHOST_BLANK_EN when the build defines it.
module tb_seg_scan_ctrl;

  localparam int T = 4;
  localparam int B = 2;
`ifdef SCAN_GHOST_BLANK_EN
  localparam int P = T + B;
`else
  localparam int P = T;
`endif

  logic       clk = 1'b0;
  logic       rst, en, use_mux;
  logic [7:0] digit_mask;
  logic [3:0] digit_nibble, nib_drv;
  logic [2:0] sel;
  logic [7:0] an_n;
  logic [6:0] seg_n;
  logic       frame_done;
  logic [31:0] digs = 32'h89ABCDEF;

  always #5 clk = ~clk;

  // Stand-in for the external 8:1 nibble mux: digit i shows value 15-i
  assign digit_nibble = use_mux ? digs[{sel, 2'b00} +: 4] : nib_drv;

  seg_scan_ctrl #(.TICK_DIV(T), .BLANK_CYCLES(B)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .digit_mask   (digit_mask),
    .digit_nibble (digit_nibble),
    .sel          (sel),
    .an_n         (an_n),
    .seg_n        (seg_n),
    .frame_done   (frame_done)
  );

  typedef struct {logic [2:0] sel; logic [7:0] an; logic fd;} exp_t;
  typedef struct {logic [3:0] nib; logic [6:0] seg;} hex_vec_t;

  exp_t       sbq[$];
  logic [6:0] segq[$];
  hex_vec_t   hv[16];
  logic [6:0] exp_seg [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: 0=idle 1=show 2=blank
  int         m_st, m_cnt;
  logic [2:0] m_sel;
  logic       m_fd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_sel = 3'd0; m_fd = 1'b0;
  endtask

  function automatic logic [7:0] m_an();
    logic [7:0] one;
    one = 8'h01 << m_sel;
    return (m_st == 1 && digit_mask[m_sel]) ? ~one : 8'hFF;
  endfunction

  // Advance the model on the current inputs, queue the expectation, clock, compare.
  task automatic step(input string tag);
    logic [2:0] ps;
    exp_t       e;
    ps   = m_sel;
    m_fd = 1'b0;
    if (!en) begin
      m_st = 0; m_cnt = 0; m_sel = 3'd0;
    end else if (m_st == 0) begin
      m_st = 1; m_cnt = 0; m_sel = 3'd0;
    end else if (m_st == 1) begin
      if (m_cnt == T - 1) begin
        m_cnt = 0;
`ifdef SCAN_GHOST_BLANK_EN
        m_st = 2;
`else
        m_sel = ps + 3'd1;
        m_fd  = (ps == 3'd7);
`endif
      end else m_cnt++;
    end else begin
      if (m_cnt == B - 1) begin
        m_st = 1; m_cnt = 0; m_sel = ps + 3'd1; m_fd = (ps == 3'd7);
      end else m_cnt++;
    end
    sbq.push_back('{m_sel, m_an(), m_fd});
    @(posedge clk); #1;
    e = sbq.pop_front();
    chk({tag, ".sel"}, sel, e.sel);
    chk({tag, ".an_n"}, an_n, e.an);
    chk({tag, ".frame_done"}, frame_done, e.fd);
  endtask

  initial begin
    exp_t       e;
    logic [2:0] es;
    logic [7:0] one;
    int         pos;

    for (int i = 0; i < 16; i++) hv[i] = '{4'(i), exp_seg[i]};

    rst = 1'b1; en = 1'b0; digit_mask = 8'hFF; use_mux = 1'b0; nib_drv = 4'h0;
    model_reset();
    @(posedge clk); #1;
    chk("reset.sel", sel, 3'd0);
    chk("reset.an_n", an_n, 8'hFF);
    chk("reset.frame_done", frame_done, 1'b0);

    // Hex decode table, zero latency
    for (int i = 0; i < 16; i++) begin
      nib_drv = hv[i].nib;
      segq.push_back(hv[i].seg);
      #1;
      chk("hex", seg_n, segq.pop_front());
    end

    // Free-running scan, expectations from slot arithmetic
    use_mux = 1'b1;
    @(negedge clk);
    en = 1'b1; rst = 1'b0;
    for (int k = 0; k <= 2 * 8 * P; k++) begin
      @(posedge clk); #1;
      pos = k % P;
      es  = 3'((k / P) % 8);
      one = 8'h01 << es;
      sbq.push_back('{es, (pos < T) ? ~one : 8'hFF, (k > 0) && (k % (8 * P) == 0)});
      e = sbq.pop_front();
      chk("scan.sel", sel, e.sel);
      chk("scan.an_n", an_n, e.an);
      chk("scan.frame_done", frame_done, e.fd);
      chk("scan.seg_n", seg_n, exp_seg[15 - int'(es)]);
    end

    // Drop en (model resets from any state), then mask 05 for a full frame
    en = 1'b0;
    step("en_off");
    digit_mask = 8'h05; en = 1'b1;
    repeat (8 * P + 2) step("mask05");
    // Mask change mid-slot takes effect next cycle without restarting the slot
    repeat (1) step("mask05b");
    digit_mask = 8'hFF;
    repeat (2 * P) step("mask_chg");

    // en dropped during slot 5
    en = 1'b0; step("restart");
    en = 1'b1;
    repeat (5 * P + 2) step("to_slot5");
    en = 1'b0;
    step("en_drop5");
    chk("en_drop5.an_ff", an_n, 8'hFF);
    chk("en_drop5.fd0", frame_done, 1'b0);
    en = 1'b1;
    step("en_rise");
    chk("en_rise.sel0", sel, 3'd0);
    chk("en_rise.an_fe", an_n, 8'hFE);

    // Asynchronous reset in the middle of slot 3
    repeat (3 * P + 1) step("to_slot3");
    #1 rst = 1'b1;
    #1;
    chk("async_rst.sel", sel, 3'd0);
    chk("async_rst.an_n", an_n, 8'hFF);
    chk("async_rst.fd", frame_done, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < T; i++) begin
      step("post_rst");
      chk("post_rst.sel0", sel, 3'd0);
      chk("post_rst.an_fe", an_n, 8'hFE);
    end
    repeat (P + 2) step("post_rst_b");

    // Random en / mask activity
    for (int i = 0; i < 80; i++) begin
      en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 7) == 0) digit_mask = 8'($urandom);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
